// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between Req0 (EX path) and Req1 (branch unit); ALU_ARB_STATS_EN adds grant/stall counters.
// Latency: accept at edge N, operands on Alu* in cycle N+1, response valid from edge N+1; one op per cycle when unstalled.
// Backpressure: a held S2 holds S1 and drops both request readys; Flush empties both stages without responding.
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int CTL_W  = 6,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Flush,
    input  logic              Req0Valid,
    input  logic              Req1Valid,
    output logic              Req0Ready,
    output logic              Req1Ready,
    input  logic [CTL_W-1:0]  Req0Ctl,
    input  logic [CTL_W-1:0]  Req1Ctl,
    input  logic [DATA_W-1:0] Req0A,
    input  logic [DATA_W-1:0] Req1A,
    input  logic [DATA_W-1:0] Req0B,
    input  logic [DATA_W-1:0] Req1B,
    output logic [CTL_W-1:0]  AluCtl,
    output logic [DATA_W-1:0] AluA,
    output logic [DATA_W-1:0] AluB,
    input  logic [DATA_W-1:0] AluResult,
    input  logic              AluZero,
    input  logic              AluOverflow,
    output logic              Resp0Valid,
    output logic              Resp1Valid,
    input  logic              Resp0Ready,
    input  logic              Resp1Ready,
`ifdef ALU_ARB_STATS_EN
    output logic [CNT_W-1:0]  Grant0Count,
    output logic [CNT_W-1:0]  Grant1Count,
    output logic [CNT_W-1:0]  StallCount,
`endif
    output logic [DATA_W-1:0] RespResult,
    output logic              RespZero,
    output logic              RespOverflow
);

    logic              s1_vld;
    logic              s1_owner;
    logic [CTL_W-1:0]  s1_ctl;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;

    logic              s2_vld;
    logic              s2_owner;
    logic [DATA_W-1:0] s2_result;
    logic              s2_zero;
    logic              s2_ovf;

    logic last_grant;
    logic consume, s2_free, s1_adv, s1_can;
    logic grant0, grant1, hs0, hs1, accept;

    assign consume = s2_vld & (s2_owner ? Resp1Ready : Resp0Ready);
    assign s2_free = !s2_vld | consume;
    assign s1_adv  = s1_vld & s2_free;
    assign s1_can  = !s1_vld | s1_adv;

    // On a tie the requester that did not win last time gets the slot.
    assign grant0 = Req0Valid & (!Req1Valid | last_grant);
    assign grant1 = Req1Valid & (!Req0Valid | !last_grant);

    // Rst gating keeps the readys low while reset is held, even with valids up.
    assign Req0Ready = grant0 & s1_can & !Flush & Rst;
    assign Req1Ready = grant1 & s1_can & !Flush & Rst;
    assign hs0       = Req0Valid & Req0Ready;
    assign hs1       = Req1Valid & Req1Ready;
    assign accept    = hs0 | hs1;

    assign AluCtl = s1_vld ? s1_ctl : '0;
    assign AluA   = s1_vld ? s1_a   : '0;
    assign AluB   = s1_vld ? s1_b   : '0;

    assign Resp0Valid   = s2_vld & !s2_owner;
    assign Resp1Valid   = s2_vld &  s2_owner;
    assign RespResult   = s2_result;
    assign RespZero     = s2_zero;
    assign RespOverflow = s2_ovf;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            s1_vld     <= 1'b0;
            s1_owner   <= 1'b0;
            s1_ctl     <= '0;
            s1_a       <= '0;
            s1_b       <= '0;
            s2_vld     <= 1'b0;
            s2_owner   <= 1'b0;
            s2_result  <= '0;
            s2_zero    <= 1'b0;
            s2_ovf     <= 1'b0;
            last_grant <= 1'b1;
        end else if (Flush) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
        end else begin
            if (accept) begin
                s1_vld     <= 1'b1;
                s1_owner   <= hs1;
                s1_ctl     <= hs1 ? Req1Ctl : Req0Ctl;
                s1_a       <= hs1 ? Req1A   : Req0A;
                s1_b       <= hs1 ? Req1B   : Req0B;
                last_grant <= hs1;
            end else if (s1_adv) begin
                s1_vld <= 1'b0;
            end

            if (s1_adv) begin
                s2_vld    <= 1'b1;
                s2_owner  <= s1_owner;
                s2_result <= AluResult;
                s2_zero   <= AluZero;
                s2_ovf    <= AluOverflow;
            end else if (consume) begin
                s2_vld <= 1'b0;
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic stall;

    assign stall = (Req0Valid | Req1Valid) & !accept;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Grant0Count <= '0;
            Grant1Count <= '0;
            StallCount  <= '0;
        end else if (Flush) begin
            Grant0Count <= '0;
            Grant1Count <= '0;
            StallCount  <= '0;
        end else begin
            if (hs0 && Grant0Count != CNT_MAX) Grant0Count <= Grant0Count + 1'b1;
            if (hs1 && Grant1Count != CNT_MAX) Grant1Count <= Grant1Count + 1'b1;
            if (stall && StallCount != CNT_MAX) StallCount <= StallCount + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter; the bench plays the ALU (4=add, 5=sub, else and).
module tb_alu_share_arbiter;

    logic        Clk, Rst, Flush;
    logic        Req0Valid, Req1Valid, Req0Ready, Req1Ready;
    logic [5:0]  Req0Ctl, Req1Ctl, AluCtl;
    logic [31:0] Req0A, Req1A, Req0B, Req1B, AluA, AluB, AluResult, RespResult;
    logic        AluZero, AluOverflow;
    logic        Resp0Valid, Resp1Valid, Resp0Ready, Resp1Ready;
    logic        RespZero, RespOverflow;
`ifdef ALU_ARB_STATS_EN
    logic [1:0]  Grant0Count, Grant1Count, StallCount;
`endif

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_tie [4] = '{32'd110, 32'd220, 32'd111, 32'd221};

    alu_share_arbiter #(.DATA_W(32), .CTL_W(6), .CNT_W(2)) dut (
        .Clk(Clk), .Rst(Rst), .Flush(Flush),
        .Req0Valid(Req0Valid), .Req1Valid(Req1Valid),
        .Req0Ready(Req0Ready), .Req1Ready(Req1Ready),
        .Req0Ctl(Req0Ctl), .Req1Ctl(Req1Ctl),
        .Req0A(Req0A), .Req1A(Req1A), .Req0B(Req0B), .Req1B(Req1B),
        .AluCtl(AluCtl), .AluA(AluA), .AluB(AluB),
        .AluResult(AluResult), .AluZero(AluZero), .AluOverflow(AluOverflow),
        .Resp0Valid(Resp0Valid), .Resp1Valid(Resp1Valid),
        .Resp0Ready(Resp0Ready), .Resp1Ready(Resp1Ready),
`ifdef ALU_ARB_STATS_EN
        .Grant0Count(Grant0Count), .Grant1Count(Grant1Count), .StallCount(StallCount),
`endif
        .RespResult(RespResult), .RespZero(RespZero), .RespOverflow(RespOverflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always_comb begin
        AluOverflow = 1'b0;
        case (AluCtl)
            6'd4: begin
                AluResult   = AluA + AluB;
                AluOverflow = (AluA[31] == AluB[31]) && (AluResult[31] != AluA[31]);
            end
            6'd5: begin
                AluResult   = AluA - AluB;
                AluOverflow = (AluA[31] != AluB[31]) && (AluResult[31] != AluA[31]);
            end
            default: AluResult = AluA & AluB;
        endcase
        AluZero = (AluResult == 32'd0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Rst = 1'b0; Flush = 1'b0;
        Req0Valid = 1'b0; Req1Valid = 1'b0;
        Req0Ctl = '0; Req1Ctl = '0;
        Req0A = '0; Req1A = '0; Req0B = '0; Req1B = '0;
        Resp0Ready = 1'b1; Resp1Ready = 1'b1;
        #2;
        chk("rst_rdy0", Req0Ready, 0);
        chk("rst_rdy1", Req1Ready, 0);
        chk("rst_resp0", Resp0Valid, 0);
        chk("rst_resp1", Resp1Valid, 0);
        chk("rst_res", RespResult, 0);
        chk("rst_aluctl", AluCtl, 0);
        chk("rst_alua", AluA, 0);
        tick;
        Rst = 1'b1;
        tick;

        // Tie after reset: grants 0,1,0,1 and responses in that order.
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
                Req0Valid = 1; Req0Ctl = 4; Req0A = 10 + (c + 1) / 2; Req0B = 100;
                Req1Valid = 1; Req1Ctl = 4; Req1A = 20 + c / 2;       Req1B = 200;
            end else begin
                Req0Valid = 0; Req1Valid = 0;
            end
            #1;
            if (c < 4) begin
                chk("tie_rdy0", Req0Ready, (c % 2 == 0));
                chk("tie_rdy1", Req1Ready, (c % 2 == 1));
            end
            if (c >= 2) begin
                chk("tie_vld0", Resp0Valid, (c % 2 == 0));
                chk("tie_vld1", Resp1Valid, (c % 2 == 1));
                chk("tie_res", RespResult, exp_tie[c-2]);
            end
            tick;
        end
        chk("tie_drain0", Resp0Valid, 0);
        chk("tie_drain1", Resp1Valid, 0);

        // Single Req0 op: 5 + 7.
        Req0Valid = 1; Req0Ctl = 4; Req0A = 5; Req0B = 7;
        #1;
        chk("one_rdy0", Req0Ready, 1);
        chk("one_rdy1", Req1Ready, 0);
        tick;
        Req0Valid = 0;
        #1;
        chk("one_aluctl", AluCtl, 4);
        chk("one_alua", AluA, 5);
        chk("one_alub", AluB, 7);
        chk("one_early", Resp0Valid, 0);
        tick;
        chk("one_vld0", Resp0Valid, 1);
        chk("one_vld1", Resp1Valid, 0);
        chk("one_res", RespResult, 12);
        chk("one_zero", RespZero, 0);
        tick;
        chk("one_done", Resp0Valid, 0);

        // Overflow forwarding through Req1.
        Req1Valid = 1; Req1Ctl = 4; Req1A = 32'h7FFF_FFFF; Req1B = 1;
        #1;
        chk("ovf_rdy1", Req1Ready, 1);
        tick;
        Req1Valid = 0;
        tick;
        chk("ovf_vld1", Resp1Valid, 1);
        chk("ovf_res", RespResult, 32'h8000_0000);
        chk("ovf_flag", RespOverflow, 1);
        tick;

        // Back-pressure: Resp0 stalled while Req1 streams 3-3.
        Resp0Ready = 0;
        Req0Valid = 1; Req0Ctl = 4; Req0A = 1; Req0B = 2;
        Req1Valid = 1; Req1Ctl = 5; Req1A = 3; Req1B = 3;
        #1;
        chk("bp_rdy0", Req0Ready, 1);
        chk("bp_rdy1a", Req1Ready, 0);
        tick;
        Req0Valid = 0;
        #1;
        chk("bp_rdy1b", Req1Ready, 1);
        tick;
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_rdy1", Req1Ready, 0);
            chk("bp_hold_vld0", Resp0Valid, 1);
            chk("bp_hold_res", RespResult, 3);
            chk("bp_hold_s1", AluCtl, 5);
            tick;
        end
        Resp0Ready = 1;
        #1;
        chk("bp_release_rdy1", Req1Ready, 1);
        tick;
        Req1Valid = 0;
        #1;
        chk("bp_r1_vld1", Resp1Valid, 1);
        chk("bp_r1_vld0", Resp0Valid, 0);
        chk("bp_r1_res", RespResult, 0);
        chk("bp_r1_zero", RespZero, 1);
        tick;
        chk("bp_r2_vld1", Resp1Valid, 1);
        chk("bp_r2_zero", RespZero, 1);
        tick;
        chk("bp_empty", Resp1Valid, 0);

        // Flush with both stages full.
        Resp0Ready = 0; Resp1Ready = 0;
        Req0Valid = 1; Req0Ctl = 4; Req0A = 1; Req0B = 1;
        tick;
        Req0Valid = 0;
        Req1Valid = 1; Req1Ctl = 4; Req1A = 2; Req1B = 2;
        #1;
        chk("fl_fill_rdy1", Req1Ready, 1);
        tick;
        Req1Valid = 0;
        chk("fl_full_vld0", Resp0Valid, 1);
        chk("fl_full_alu", AluA, 2);
        Req0Valid = 1; Req1Valid = 1; Resp0Ready = 1; Resp1Ready = 1;
        Flush = 1;
        #1;
        chk("fl_rdy0", Req0Ready, 0);
        chk("fl_rdy1", Req1Ready, 0);
        tick;
        Flush = 0; Req0Valid = 0; Req1Valid = 0;
        #1;
        chk("fl_vld0", Resp0Valid, 0);
        chk("fl_vld1", Resp1Valid, 0);
        chk("fl_aluctl", AluCtl, 0);
        tick;
        chk("fl_late", Resp0Valid | Resp1Valid, 0);

        // Back-to-back Req0 stream: one accept per cycle.
        for (int i = 0; i < 5; i++) begin
            Req0Valid = 1; Req0Ctl = 4; Req0A = i; Req0B = 1;
            #1;
            chk("b2b_rdy0", Req0Ready, 1);
            if (i >= 2) chk("b2b_res", RespResult, i - 1);
            tick;
        end
        Req0Valid = 0;
`ifdef ALU_ARB_STATS_EN
        chk("st_g0", Grant0Count, 3);
        chk("st_g1", Grant1Count, 0);
        chk("st_stall", StallCount, 0);
`endif
        tick;
        tick;
        Flush = 1;
        tick;
        Flush = 0;
`ifdef ALU_ARB_STATS_EN
        chk("st_fl_g0", Grant0Count, 0);
        chk("st_fl_g1", Grant1Count, 0);
        chk("st_fl_stall", StallCount, 0);
`endif

        // Asynchronous reset mid-stream, then a fresh tie favours Req0.
        Req0Valid = 1; Req0Ctl = 4; Req0A = 9; Req0B = 9;
        tick;
        Req0Valid = 0;
        Req1Valid = 1; Req1Ctl = 4; Req1A = 8; Req1B = 8;
        tick;
        Req0Valid = 1;
        #2;
        Rst = 0;
        #1;
        chk("ar_vld0", Resp0Valid, 0);
        chk("ar_vld1", Resp1Valid, 0);
        chk("ar_res", RespResult, 0);
        chk("ar_alua", AluA, 0);
        chk("ar_rdy0", Req0Ready, 0);
        chk("ar_rdy1", Req1Ready, 0);
        #2;
        Rst = 1;
        #1;
        chk("ar_tie_rdy0", Req0Ready, 1);
        chk("ar_tie_rdy1", Req1Ready, 0);
        tick;
        chk("ar_next_rdy1", Req1Ready, 1);
        chk("ar_next_rdy0", Req0Ready, 0);
        Req0Valid = 0; Req1Valid = 0;
        tick;
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 32-bit ALU between two requesters (Req0 = integer EX path, Req1 = branch/compare unit).
- Round-robin arbitration with valid/ready handshakes on both the request and response sides.
- Two-stage buffer: an operand register drives the external ALU, and a result register holds its outputs.
- Sustains one operation per cycle when the response side is not back-pressured.

Parameters:
DATA_W, 32, operand/result width
CTL_W, 6, ALU control width (0..17 are legal opcodes; other codes pass through unchecked)
CNT_W, 16, statistics counter width (used only with the optional feature)

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  asynchronous, active-low reset
Flush  in  1  synchronous; discards all in-flight operations
Req0Valid, Req1Valid  in  1  request valid
Req0Ready, Req1Ready  out  1  request accepted this cycle
Req0Ctl, Req1Ctl  in  CTL_W  ALU opcode
Req0A, Req1A, Req0B, Req1B  in  DATA_W  operands
AluCtl  out  CTL_W  to the ALU
AluA, AluB  out  DATA_W  to the ALU
AluResult  in  DATA_W  from the ALU
AluZero, AluOverflow  in  1  from the ALU
Resp0Valid, Resp1Valid  out  1  response valid for requester i
Resp0Ready, Resp1Ready  in  1  requester i consumes its response
RespResult  out  DATA_W  shared response data
RespZero, RespOverflow  out  1  shared response flags

Behaviour:
- Stage 1 (S1) registers: S1Valid, S1Owner, Ctl, A, B. AluCtl/AluA/AluB are driven from S1 when S1Valid=1, otherwise all zero.
- Stage 2 (S2) registers: S2Valid, S2Owner, Result, Zero, Overflow, captured from the Alu* inputs when S1 advances.
- RespiValid = S2Valid & (S2Owner==i). RespResult, RespZero and RespOverflow always reflect S2.
- Consume = S2Valid & RespReady of the S2 owner.
- S2Free = !S2Valid | Consume.
- S1 advances when S1Valid & S2Free. S1 can accept when !S1Valid | S1Advances.
- Arbitration:
  - Only one requester valid: that requester gets the grant.
  - Both valid: grant goes to the requester not in LastGrant.
  - ReqiReady = grant_i & S1CanAccept & !Flush. At most one Ready is high per cycle.
  - Ready may depend combinationally on both Valids. A requester's Valid must not depend on its Ready. Valid and operands stay stable until accepted.
  - LastGrant updates only on an accepted handshake.
- Latency:
  - Handshake at edge N → operands on Alu* during cycle N+1.
  - Result captured at edge N+1 → RespiValid high from N+1, held until consumed.
  - Back-to-back: one accept per cycle with RespReady held high.
- Back-pressure: while S2 is held, S1 holds its operation and both Readys stay low. No operation is ever dropped or reordered; responses return in acceptance order.
- Simultaneous consume of S2 and advance of S1 in the same cycle: S2 reloads with no bubble.
- Flush: at the next edge S1Valid and S2Valid clear. Readys are low during the Flush cycle. LastGrant is unchanged.
- Reset (Rst low, asynchronous, any time, including mid-operation):
  - S1Valid, S2Valid, S1Owner, S2Owner, all S1/S2 data registers = 0; LastGrant = 1 (Req0 wins the first tie).
  - All outputs 0. In-flight operations are lost with no response.
- Opcode is not decoded. Overflow and Zero are forwarded exactly as returned by the ALU.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- Defined: adds outputs Grant0Count, Grant1Count and StallCount, each CNT_W wide, reset to 0, cleared by Flush.
  - GrantiCount increments on each requester-i handshake.
  - StallCount increments on each cycle with any ReqiValid=1 and no handshake.
  - All counters saturate at all-ones.
- Undefined: these ports and registers are absent; behaviour is otherwise identical.

Test Plan:
- Single op: Req0 sends Ctl=4, A=5, B=7, RespReady=1 → Req0Ready same cycle; Resp0Valid one cycle later with RespResult=12, RespZero=0; Resp1Valid stays 0.
- Tie round-robin: both Valid every cycle for 4 cycles after reset, RespReady=1 → grants in order 0,1,0,1; responses arrive in the same order, one per cycle.
- Back-pressure: Resp0Ready=0 for 3 cycles while Req1 streams (Ctl=5, A=3, B=3) → S2 holds the Req0 result, one Req1 op waits in S1, Req1Ready=0; after release, Req1 RespResult=0 with RespZero=1 and no op lost.
- Overflow forwarding: Ctl=4, A=32'h7FFFFFFF, B=1 → RespResult=32'h80000000, RespOverflow=1.
- Flush and reset: Flush asserted with S1 and S2 both full → no response appears and both Readys are low that cycle. Rst pulsed low mid-stream → all outputs 0 immediately (asynchronous), then a Req0/Req1 tie grants Req0 first.
- Stats (ALU_ARB_STATS_EN defined, CNT_W=2): 5 Req0 grants → Grant0Count saturates at 3; Flush → all counters 0.
